// File: rtl/serial_port_pkg.sv
// Shared types and defaults for the serial port responder.
//   serial_byte_t        - one byte on the processor/host serial paths
//   SERIAL_DEFAULT_DEPTH - default number of entries per FIFO
package serial_port_pkg;

  typedef logic [7:0] serial_byte_t;

  localparam int SERIAL_DEFAULT_DEPTH = 16;

endpackage

// File: rtl/serial_byte_fifo.sv
// Byte FIFO with first-word fall-through head output.
// Push and pop requests are qualified internally against full/empty, so a
// push while full or a pop while empty leaves the FIFO untouched.
// Ports:
//   clock, reset      - rising-edge clock, synchronous active-low reset
//   push, push_data   - write request and byte
//   pop               - remove the head entry
//   head_data         - current head entry (stale when empty)
//   full, empty       - occupancy boundaries
//   count             - number of entries held (0..DEPTH)
module serial_byte_fifo
  import serial_port_pkg::*;
#(
  parameter int DEPTH = SERIAL_DEFAULT_DEPTH
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  serial_byte_t             push_data,
  input  logic                     pop,
  output serial_byte_t             head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  serial_byte_t    mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count_q;
  logic            do_push;
  logic            do_pop;

  assign full    = (count_q == CNT_FULL);
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage is cleared on reset so the head output reads 0x00 afterwards.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_data = mem[rd_ptr];
  assign count     = count_q;

endmodule

// File: rtl/serial_port_responder.sv
// Device-side endpoint of the processor byte-serial port.
// RX FIFO: host -> processor. TX FIFO: processor -> host.
// Optional feature macro: SERIAL_PORT_LOOPBACK_EN adds loopback_in, which
// steers TX FIFO pops into the RX FIFO and blocks the host handshakes.
// Ports:
//   clock, reset                        - clock, synchronous active-low reset
//   serial_data_out / serial_valid_out  - RX head and non-empty to processor
//   serial_rden_in                      - processor pops the RX head
//   serial_data_in / serial_wren_in     - processor byte into the TX FIFO
//   serial_ready_out                    - TX FIFO not full
//   host_rx_data/valid, host_rx_ready   - host byte into the RX FIFO
//   host_tx_data/valid, host_tx_ready   - TX head out to the host
//   rx_underflow, tx_overflow           - sticky error flags
//   loopback_in (macro only)            - route TX into RX
module serial_port_responder
  import serial_port_pkg::*;
#(
  parameter int DEPTH = SERIAL_DEFAULT_DEPTH
) (
  input  logic          clock,
  input  logic          reset,
`ifdef SERIAL_PORT_LOOPBACK_EN
  input  logic          loopback_in,
`endif
  output serial_byte_t  serial_data_out,
  output logic          serial_valid_out,
  input  logic          serial_rden_in,
  input  serial_byte_t  serial_data_in,
  input  logic          serial_wren_in,
  output logic          serial_ready_out,
  input  serial_byte_t  host_rx_data,
  input  logic          host_rx_valid,
  output logic          host_rx_ready,
  output serial_byte_t  host_tx_data,
  output logic          host_tx_valid,
  input  logic          host_tx_ready,
  output logic          rx_underflow,
  output logic          tx_overflow
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  serial_byte_t   rx_head;
  serial_byte_t   tx_head;
  serial_byte_t   rx_push_data;
  logic           rx_full, rx_empty, tx_full, tx_empty;
  logic [CW-1:0]  rx_count, tx_count;
  logic           rx_push, rx_pop, tx_push, tx_pop;
  logic           lb_move;
  logic           lb_q;

  // Loopback mode is registered so a change on loopback_in applies from
  // the next edge and never forms a combinational path to the outputs.
`ifdef SERIAL_PORT_LOOPBACK_EN
  always_ff @(posedge clock) begin
    if (!reset) begin
      lb_q <= 1'b0;
    end else begin
      lb_q <= loopback_in;
    end
  end
`else
  assign lb_q = 1'b0;
`endif

  always_comb begin
    rx_pop       = serial_rden_in && !rx_empty;
    tx_push      = serial_wren_in && !tx_full;
    lb_move      = lb_q && !tx_empty && !rx_full;
    rx_push      = host_rx_valid && !rx_full;
    rx_push_data = host_rx_data;
    tx_pop       = host_tx_ready && !tx_empty;
    if (lb_q) begin
      rx_push      = lb_move;
      rx_push_data = tx_head;
      tx_pop       = lb_move;
    end
  end

  serial_byte_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (rx_push),
    .push_data (rx_push_data),
    .pop       (rx_pop),
    .head_data (rx_head),
    .full      (rx_full),
    .empty     (rx_empty),
    .count     (rx_count)
  );

  serial_byte_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (tx_push),
    .push_data (serial_data_in),
    .pop       (tx_pop),
    .head_data (tx_head),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_count)
  );

  // Error detection compares occupancy directly (same condition as empty/full).
  always_ff @(posedge clock) begin
    if (!reset) begin
      rx_underflow <= 1'b0;
      tx_overflow  <= 1'b0;
    end else begin
      if (serial_rden_in && (rx_count == '0)) begin
        rx_underflow <= 1'b1;
      end
      if (serial_wren_in && (tx_count == CNT_FULL)) begin
        tx_overflow <= 1'b1;
      end
    end
  end

  assign serial_data_out  = rx_head;
  assign serial_valid_out = !rx_empty;
  assign serial_ready_out = !tx_full;
  assign host_rx_ready    = !rx_full && !lb_q;
  assign host_tx_data     = tx_head;
  assign host_tx_valid    = !tx_empty && !lb_q;

endmodule

// File: tb/tb_serial_port_responder.sv
// Self-checking bench for serial_port_responder.
// A queue-based model tracks the bytes each FIFO must hold; a compare
// process checks every output against it on each falling edge, and the
// directed sequence adds literal expectations of its own.
module tb_serial_port_responder;
  import serial_port_pkg::*;

  localparam int DEPTH = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
`ifdef SERIAL_PORT_LOOPBACK_EN
  logic          loopback_in = 1'b0;
`endif
  serial_byte_t  serial_data_out;
  logic          serial_valid_out;
  logic          serial_rden_in = 1'b0;
  serial_byte_t  serial_data_in = '0;
  logic          serial_wren_in = 1'b0;
  logic          serial_ready_out;
  serial_byte_t  host_rx_data = '0;
  logic          host_rx_valid = 1'b0;
  logic          host_rx_ready;
  serial_byte_t  host_tx_data;
  logic          host_tx_valid;
  logic          host_tx_ready = 1'b0;
  logic          rx_underflow;
  logic          tx_overflow;

  serial_port_responder #(.DEPTH(DEPTH)) dut (
    .clock            (clock),
    .reset            (reset),
`ifdef SERIAL_PORT_LOOPBACK_EN
    .loopback_in      (loopback_in),
`endif
    .serial_data_out  (serial_data_out),
    .serial_valid_out (serial_valid_out),
    .serial_rden_in   (serial_rden_in),
    .serial_data_in   (serial_data_in),
    .serial_wren_in   (serial_wren_in),
    .serial_ready_out (serial_ready_out),
    .host_rx_data     (host_rx_data),
    .host_rx_valid    (host_rx_valid),
    .host_rx_ready    (host_rx_ready),
    .host_tx_data     (host_tx_data),
    .host_tx_valid    (host_tx_valid),
    .host_tx_ready    (host_tx_ready),
    .rx_underflow     (rx_underflow),
    .tx_overflow      (tx_overflow)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%02h required=%02h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: byte queues plus sticky flags and loopback mode.
  serial_byte_t m_rx[$];
  serial_byte_t m_tx[$];
  bit m_uf = 1'b0;
  bit m_ov = 1'b0;
  bit m_lb = 1'b0;

  always @(posedge clock) begin
    int rx_n;
    int tx_n;
    serial_byte_t b;
    if (!reset) begin
      m_rx.delete();
      m_tx.delete();
      m_uf = 1'b0;
      m_ov = 1'b0;
      m_lb = 1'b0;
    end else begin
      rx_n = m_rx.size();
      tx_n = m_tx.size();
      if (serial_rden_in) begin
        if (rx_n > 0) void'(m_rx.pop_front());
        else m_uf = 1'b1;
      end
      if (serial_wren_in) begin
        if (tx_n < DEPTH) m_tx.push_back(serial_data_in);
        else m_ov = 1'b1;
      end
      if (m_lb) begin
        if (tx_n > 0 && rx_n < DEPTH) begin
          b = m_tx.pop_front();
          m_rx.push_back(b);
        end
      end else begin
        if (host_rx_valid && rx_n < DEPTH) m_rx.push_back(host_rx_data);
        if (host_tx_ready && tx_n > 0) void'(m_tx.pop_front());
      end
`ifdef SERIAL_PORT_LOOPBACK_EN
      m_lb = loopback_in;
`endif
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("serial_valid_out", serial_valid_out, m_rx.size() != 0);
      check("host_rx_ready", host_rx_ready, (m_rx.size() < DEPTH) && !m_lb);
      check("serial_ready_out", serial_ready_out, m_tx.size() < DEPTH);
      check("host_tx_valid", host_tx_valid, (m_tx.size() != 0) && !m_lb);
      check("rx_underflow", rx_underflow, m_uf);
      check("tx_overflow", tx_overflow, m_ov);
      if (m_rx.size() != 0) check("serial_data_out", serial_data_out, m_rx[0]);
      if (m_tx.size() != 0) check("host_tx_data", host_tx_data, m_tx[0]);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    // Reset and idle
    tick();
    tick();
    chk_en = 1'b1;
    reset = 1'b1;
    repeat (3) tick();
    check("lit_reset_valid", serial_valid_out, 1'b0);
    check("lit_reset_ready", serial_ready_out, 1'b1);
    check("lit_reset_rx_ready", host_rx_ready, 1'b1);
    check("lit_reset_tx_valid", host_tx_valid, 1'b0);
    check("lit_reset_uf", rx_underflow, 1'b0);
    check("lit_reset_ov", tx_overflow, 1'b0);
    check("lit_reset_rx_data", serial_data_out, 8'h00);
    check("lit_reset_tx_data", host_tx_data, 8'h00);

    // Host sends three bytes, processor pops one per cycle one cycle later
    host_rx_valid = 1'b1; host_rx_data = 8'hAA;
    tick();
    host_rx_data = 8'h55; serial_rden_in = 1'b1;
    check("lit_rx_byte0", serial_data_out, 8'hAA);
    tick();
    host_rx_data = 8'h0D;
    check("lit_rx_byte1", serial_data_out, 8'h55);
    tick();
    host_rx_valid = 1'b0;
    check("lit_rx_byte2", serial_data_out, 8'h0D);
    tick();
    serial_rden_in = 1'b0;
    check("lit_rx_drained", serial_valid_out, 1'b0);

    // Fill TX, overflow, then drain
    serial_wren_in = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      serial_data_in = 8'(i);
      tick();
    end
    check("lit_tx_full_ready", serial_ready_out, 1'b0);
    serial_data_in = 8'hFF;
    tick();
    serial_wren_in = 1'b0;
    check("lit_tx_overflow", tx_overflow, 1'b1);
    host_tx_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      check("lit_tx_drain_valid", host_tx_valid, 1'b1);
      check("lit_tx_drain_data", host_tx_data, 8'(i));
      tick();
    end
    host_tx_ready = 1'b0;
    check("lit_tx_empty", host_tx_valid, 1'b0);

    // Pop from empty RX
    serial_rden_in = 1'b1;
    tick();
    serial_rden_in = 1'b0;
    check("lit_underflow_set", rx_underflow, 1'b1);
    tick();
    tick();
    check("lit_underflow_sticky", rx_underflow, 1'b1);
    check("lit_underflow_empty", serial_valid_out, 1'b0);

    // Steady state of 4 bytes across pointer wrap
    host_rx_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      host_rx_data = 8'(8'h10 + i);
      tick();
    end
    serial_rden_in = 1'b1;
    for (int i = 0; i < 40; i++) begin
      host_rx_data = 8'(8'h14 + i);
      check("lit_stream_head", serial_data_out, 8'(8'h10 + i));
      tick();
    end
    host_rx_valid = 1'b0;
    for (int j = 0; j < 4; j++) begin
      check("lit_stream_tail", serial_data_out, 8'(8'h38 + j));
      tick();
    end
    serial_rden_in = 1'b0;
    check("lit_stream_empty", serial_valid_out, 1'b0);

    // RX full: simultaneous pop does not open ready in that cycle
    host_rx_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      host_rx_data = 8'(8'h80 + i);
      tick();
    end
    check("lit_rx_full_ready", host_rx_ready, 1'b0);
    host_rx_data = 8'h99; serial_rden_in = 1'b1;
    check("lit_rx_full_head", serial_data_out, 8'h80);
    tick();
    host_rx_valid = 1'b0;
    check("lit_rx_reopen", host_rx_ready, 1'b1);
    for (int j = 0; j < DEPTH - 1; j++) begin
      check("lit_rx_full_drain", serial_data_out, 8'(8'h81 + j));
      tick();
    end
    serial_rden_in = 1'b0;
    check("lit_rx_no_99", serial_valid_out, 1'b0);

    // Reset with 8 bytes in TX, inputs active during the reset cycle
    serial_wren_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      serial_data_in = 8'(8'h60 + i);
      tick();
    end
    reset = 1'b0;
    serial_data_in = 8'h77; host_rx_valid = 1'b1; host_rx_data = 8'h33;
    tick();
    reset = 1'b1;
    serial_wren_in = 1'b0; host_rx_valid = 1'b0;
    check("lit_mid_reset_tx_valid", host_tx_valid, 1'b0);
    check("lit_mid_reset_ready", serial_ready_out, 1'b1);
    check("lit_mid_reset_rx_valid", serial_valid_out, 1'b0);
    check("lit_mid_reset_uf", rx_underflow, 1'b0);
    check("lit_mid_reset_ov", tx_overflow, 1'b0);
    tick();

`ifdef SERIAL_PORT_LOOPBACK_EN
    // Loopback: processor byte returns on the RX side
    loopback_in = 1'b1;
    tick();
    serial_wren_in = 1'b1; serial_data_in = 8'h41; host_rx_valid = 1'b1; host_rx_data = 8'hEE;
    tick();
    serial_wren_in = 1'b0;
    check("lit_lb_tx_valid", host_tx_valid, 1'b0);
    check("lit_lb_rx_ready", host_rx_ready, 1'b0);
    for (int k = 0; k < 3 && !serial_valid_out; k++) tick();
    host_rx_valid = 1'b0;
    check("lit_lb_arrived", serial_valid_out, 1'b1);
    check("lit_lb_data", serial_data_out, 8'h41);
    serial_rden_in = 1'b1;
    tick();
    serial_rden_in = 1'b0;
    loopback_in = 1'b0;
    tick();
    tick();
    check("lit_lb_done", serial_valid_out, 1'b0);
`endif

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_port_responder.md
# serial_port_responder

Device-side endpoint of the processor's byte-serial port. Accepts bytes from an external host into an RX FIFO and presents them to the processor (`serial_valid`/`serial_rden`); captures processor output bytes (`serial_wren`) into a TX FIFO, gated by `serial_ready`, and drains them to the host with a valid/ready handshake. Sits between the processor core and the board-level UART/host model.

## Interface
Parameters:
- `DEPTH`, 16: entries per FIFO; power of two, ≥ 2.

Ports:
- `clock`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-low.
- `serial_data_out`  out  8  RX FIFO head byte to the processor (first-word fall-through).
- `serial_valid_out`  out  1  RX FIFO non-empty.
- `serial_rden_in`  in  1  processor pops the RX head this cycle.
- `serial_data_in`  in  8  processor output byte.
- `serial_wren_in`  in  1  processor writes `serial_data_in` this cycle.
- `serial_ready_out`  out  1  TX FIFO not full.
- `host_rx_data`  in  8  byte from the host.
- `host_rx_valid`  in  1  host byte offered.
- `host_rx_ready`  out  1  RX FIFO not full.
- `host_tx_data`  out  8  TX FIFO head byte to the host.
- `host_tx_valid`  out  1  TX FIFO non-empty.
- `host_tx_ready`  in  1  host accepts the TX head.
- `rx_underflow`  out  1  sticky: `serial_rden_in` while `serial_valid_out` low.
- `tx_overflow`  out  1  sticky: `serial_wren_in` while `serial_ready_out` low.

## Operation
- RX path: push when `host_rx_valid && host_rx_ready`; pop when `serial_rden_in && serial_valid_out`.
- TX path: push when `serial_wren_in && serial_ready_out`; pop when `host_tx_valid && host_tx_ready`.
- Each FIFO has read/write pointers of `$clog2(DEPTH)` bits that wrap modulo DEPTH, and an occupancy count of `$clog2(DEPTH)+1` bits. Full means count == DEPTH; empty means count == 0.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- When full, ready is low; a simultaneous pop does not open ready in that cycle. There is no same-cycle pass-through.
- When empty, valid is low and a pop request is ignored. A byte pushed into an empty FIFO becomes visible on the following cycle.
- An illegal `serial_rden_in` does not change the RX FIFO and sets `rx_underflow`.
- An illegal `serial_wren_in` drops the byte and sets `tx_overflow`.
- Sticky flags clear only on reset.
- Data outputs always show the head entry, including the stale entry when the FIFO is empty. Benches must ignore them while valid is low.

## Timing
- Reset (`reset` == 0 at a rising edge): pointers and counts go to 0 and both flags clear. As a result `serial_valid_out`=0, `host_tx_valid`=0, `serial_ready_out`=1, `host_rx_ready`=1, and the data outputs read 0x00. FIFO RAM contents are don't-care.
- Reset mid-transfer discards all buffered bytes. Inputs asserted in the reset cycle are ignored.
- Latency, host to processor: a byte accepted at edge N has `serial_valid_out` high after edge N and can be popped at edge N+1.
- Latency, processor to host: the same, 1 cycle from push edge to `host_tx_valid`.
- All outputs are derived from registers (count, pointers, flags) with no combinational path from inputs. The FIFO storage read is asynchronous from the registered read pointer.
- Sustained throughput is 1 byte/cycle per direction when neither FIFO is at a boundary.

## Configuration
- `SERIAL_PORT_LOOPBACK_EN`, when defined:
  - Adds port `loopback_in  in  1`.
  - While `loopback_in`=1, TX FIFO pops are steered into the RX FIFO: pop when TX is non-empty and RX is not full. `host_tx_valid` is forced to 0, `host_rx_ready` is forced to 0, and `host_rx_valid` is ignored.
  - A change of `loopback_in` takes effect at the next edge. Bytes already in flight are not lost.
- When not defined: no `loopback_in` port, and the paths are always as described in Operation.

## Structure
- Shared package `serial_port_pkg`: `typedef logic [7:0] serial_byte_t`, `localparam SERIAL_DEFAULT_DEPTH = 16`.
- One sub-module, `serial_byte_fifo`, instantiated twice (RX, TX):
  - Parameter: DEPTH.
  - Ports: clock, reset, push, push_data, pop, head_data, full, empty, count.
- The top level holds the handshake qualification, the sticky flags and the loopback mux.

## Test plan
- Reset, then idle 3 cycles: `serial_valid_out`=0, `serial_ready_out`=1, `host_rx_ready`=1, both flags 0.
- Host pushes 0xAA, 0x55, 0x0D; processor pops one per cycle starting 1 cycle later: `serial_data_out` reads 0xAA, 0x55, 0x0D in order, then valid drops.
- Processor writes 16 bytes 0x00..0x0F with `host_tx_ready`=0: `serial_ready_out` goes 0 after the 16th. A 17th write (0xFF) is dropped and sets `tx_overflow`. Raising `host_tx_ready` drains 0x00..0x0F with no 0xFF.
- `serial_rden_in` pulsed with RX FIFO empty: `rx_underflow`=1 and stays 1. RX count stays 0.
- RX FIFO holds 4 bytes, host pushes and processor pops every cycle for 40 cycles: count stays 4, order is preserved across pointer wrap.
- Assert reset with 8 bytes in TX: the next cycle shows `host_tx_valid`=0, `serial_ready_out`=1, flags 0. With loopback enabled and `loopback_in`=1, writing 0x41 appears at `serial_data_out` within 3 cycles.
